// File: rtl/key_debounce_pkg.sv
// Shared state encoding and default sizing for the key debouncer.
package key_debounce_pkg;

    localparam int DEB_CYC_DEFAULT  = 1000;
    localparam int LONG_CYC_DEFAULT = 100000;
    localparam int CNT_W_DEFAULT    = 20;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DEB,
        PRESSED,
        LONG_HELD,
        RELEASE_DEB
    } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// Key debouncer with press/release/long-press strobes; every output is registered
// from the next-state decode so strobes line up with the state they announce.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEFAULT,
    parameter int LONG_CYC = LONG_CYC_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic key_sync,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] hold_inc;
    logic             long_flag, long_flag_nxt;
    logic             level_nxt, press_nxt, release_nxt, long_nxt;

    always_comb begin
        hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_ONE;
    end

    // The entry sample of each debounce state counts as 1, so the exit compare is against DEB_CYC-1.
    always_comb begin
        state_nxt     = state;
        deb_cnt_nxt   = deb_cnt;
        hold_cnt_nxt  = hold_cnt;
        long_flag_nxt = long_flag;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;

        if (!en) begin
            state_nxt     = IDLE;
            deb_cnt_nxt   = '0;
            hold_cnt_nxt  = '0;
            long_flag_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_sync) begin
                        state_nxt   = PRESS_DEB;
                        deb_cnt_nxt = CNT_ONE;
                    end
                end
                PRESS_DEB: begin
                    if (!key_sync) begin
                        state_nxt   = IDLE;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state_nxt    = PRESSED;
                        deb_cnt_nxt  = '0;
                        hold_cnt_nxt = '0;
                        press_nxt    = 1'b1;
                    end else begin
                        deb_cnt_nxt = deb_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    hold_cnt_nxt = hold_inc;
                    if (!key_sync) begin
                        state_nxt   = RELEASE_DEB;
                        deb_cnt_nxt = CNT_ONE;
                    end else if (hold_cnt >= LONG_LAST) begin
                        state_nxt     = LONG_HELD;
                        long_flag_nxt = 1'b1;
                        long_nxt      = 1'b1;
                    end
                end
                LONG_HELD: begin
                    hold_cnt_nxt = hold_inc;
                    if (!key_sync) begin
                        state_nxt   = RELEASE_DEB;
                        deb_cnt_nxt = CNT_ONE;
                    end
                end
                RELEASE_DEB: begin
                    // hold_cnt stays frozen here, so a release bounce delays the long press
                    if (key_sync) begin
                        state_nxt   = long_flag ? LONG_HELD : PRESSED;
                        deb_cnt_nxt = '0;
                    end else if (deb_cnt >= DEB_LAST) begin
                        state_nxt     = IDLE;
                        deb_cnt_nxt   = '0;
                        hold_cnt_nxt  = '0;
                        long_flag_nxt = 1'b0;
                        release_nxt   = 1'b1;
                    end else begin
                        deb_cnt_nxt = deb_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    deb_cnt_nxt   = '0;
                    hold_cnt_nxt  = '0;
                    long_flag_nxt = 1'b0;
                end
            endcase
        end

        level_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                    (state_nxt == RELEASE_DEB);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_flag     <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            long_flag     <= long_flag_nxt;
            key_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: a run-length reference model predicts level and strobes,
// a monitor pops the predictions as the DUT produces outputs.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int CW   = 8;
    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;

    logic clk      = 1'b0;
    logic rstn     = 1'b0;
    logic en       = 1'b0;
    logic key_sync = 1'b0;
    logic key_level, press_pulse, release_pulse, long_pulse;

    typedef struct { int tag; logic level; } lvl_exp_t;
    typedef struct { int tag; int kind; } evt_exp_t;

    lvl_exp_t lvl_q[$];
    evt_exp_t evt_q[$];

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    // reference model: debounced level, length of the current run disagreeing with it,
    // stable held samples since the press, and whether this press already reported long
    logic m_lvl       = 1'b0;
    int   m_run       = 0;
    int   m_hold      = 0;
    logic m_long_done = 1'b0;

    key_debounce #(.DEB_CYC(DEB), .LONG_CYC(LONG), .CNT_W(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .key_sync     (key_sync),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic modelClear();
        m_lvl       = 1'b0;
        m_run       = 0;
        m_hold      = 0;
        m_long_done = 1'b0;
    endtask

    // Predicts the outputs that appear after the coming rising edge.
    task automatic modelStep(input logic k, input logic e, input logic r_n);
        int tag;
        tag = cyc + 1;
        if (!r_n || !e) begin
            modelClear();
        end else if (!m_lvl) begin
            m_run = k ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_lvl  = 1'b1;
                m_run  = 0;
                m_hold = 0;
                evt_q.push_back('{tag, EV_PRESS});
            end
        end else if (m_run == 0) begin
            if (k && !m_long_done && m_hold >= LONG - 1) begin
                m_long_done = 1'b1;
                evt_q.push_back('{tag, EV_LONG});
            end
            if (m_hold < (1 << CW) - 1) m_hold++;
            if (!k) m_run = 1;
        end else begin
            if (k) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB) begin
                    evt_q.push_back('{tag, EV_RELEASE});
                    modelClear();
                end
            end
        end
        lvl_q.push_back('{tag, m_lvl});
    endtask

    task automatic applyStimulus(input logic k, input logic e, input logic r_n);
        @(negedge clk);
        if (rstn && !r_n) begin
            rstn = 1'b0;
            #1;
            checkOutput("async reset key_level", int'(key_level), 0);
            checkOutput("async reset press_pulse", int'(press_pulse), 0);
            checkOutput("async reset release_pulse", int'(release_pulse), 0);
            checkOutput("async reset long_pulse", int'(long_pulse), 0);
        end else begin
            rstn = r_n;
        end
        key_sync = k;
        en       = e;
        modelStep(k, e, r_n);
    endtask

    task automatic driveLevel(input logic k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(k, 1'b1, 1'b1);
    endtask

    initial begin : monitor
        int nstb;
        int kind;
        lvl_exp_t le;
        evt_exp_t ev;
        forever begin
            @(posedge clk);
            #2;
            if (lvl_q.size() > 0 && lvl_q[0].tag <= cyc) begin
                le = lvl_q.pop_front();
                checkOutput("key_level", int'(key_level), int'(le.level));
            end
            nstb = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
            if (nstb > 1) checkOutput("strobes exclusive", nstb, 1);
            if (nstb != 0) begin
                kind = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
                if (evt_q.size() == 0) begin
                    checkOutput("unexpected strobe", nstb, 0);
                end else begin
                    ev = evt_q.pop_front();
                    checkOutput("strobe kind", kind, ev.kind);
                    checkOutput("strobe cycle", cyc, ev.tag);
                end
            end else if (evt_q.size() > 0 && evt_q[0].tag <= cyc) begin
                ev = evt_q.pop_front();
                checkOutput("missing strobe", nstb, 1);
            end
        end
    end

    initial begin : stimulus
        int len;
        logic lv;

        // reset held with the key already down: nothing may leak out
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset key_level", int'(key_level), 0);
        checkOutput("reset press_pulse", int'(press_pulse), 0);
        checkOutput("reset release_pulse", int'(release_pulse), 0);
        checkOutput("reset long_pulse", int'(long_pulse), 0);
        driveLevel(1'b1, 8);
        driveLevel(1'b0, 6);

        // clean press and release
        driveLevel(1'b0, 3);
        driveLevel(1'b1, 10);
        driveLevel(1'b0, 6);

        // press bounce never qualifies
        for (int r = 0; r < 10; r++) begin
            driveLevel(1'b1, 3);
            driveLevel(1'b0, 1);
        end
        driveLevel(1'b0, 4);

        // long press then release
        driveLevel(1'b1, DEB + 40);
        driveLevel(1'b0, 8);

        // release bounce while pressed pushes the long strobe out
        driveLevel(1'b1, DEB + 5);
        driveLevel(1'b0, 2);
        driveLevel(1'b1, 30);
        driveLevel(1'b0, 6);

        // enable dropped while long-held
        driveLevel(1'b1, DEB + 22);
        applyStimulus(1'b1, 1'b0, 1'b1);
        driveLevel(1'b0, 6);

        // reset asserted while long-held
        driveLevel(1'b1, DEB + 22);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        driveLevel(1'b0, 6);

        // randomized runs mixing short bounces and long holds
        for (int b = 0; b < 160; b++) begin
            lv  = b[0];
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
            for (int i = 0; i < len; i++) begin
                applyStimulus(lv, ($urandom_range(0, 199) != 0), ($urandom_range(0, 499) != 0));
            end
        end

        driveLevel(1'b0, 8);
        repeat (3) @(negedge clk);
        checkOutput("pending strobes drained", evt_q.size(), 0);
        checkOutput("pending levels drained", lvl_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CYC, default 1000, consecutive stable samples needed to accept a level change (legal range >= 2).
REQ-002 SHALL have parameter LONG_CYC, default 100000, held cycles in PRESSED before a long press is flagged (legal range > DEB_CYC).
REQ-003 SHALL have parameter CNT_W, default 20, counter width (2**CNT_W > LONG_CYC).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  synchronous enable; 0 forces IDLE.
REQ-007 SHALL have port key_sync  input  1  raw key level, already synchronous to clk (no synchronizer inside this block).
REQ-008 SHALL have port key_level  output  1  debounced key level.
REQ-009 SHALL have port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-010 SHALL have port release_pulse  output  1  one-cycle strobe on accepted release.
REQ-011 SHALL have port long_pulse  output  1  one-cycle strobe when a press has been held LONG_CYC cycles.

Function
REQ-012 SHALL implement FSM states IDLE, PRESS_DEB, PRESSED, LONG_HELD, RELEASE_DEB; all outputs registered.
REQ-013 IDLE: key_sync=1 -> PRESS_DEB, with deb_cnt counting this sample as 1.
REQ-014 PRESS_DEB: key_sync=0 -> IDLE, no strobe; key_sync=1 on DEB_CYC consecutive edges (including the IDLE sample) -> PRESSED, hold_cnt=0, press_pulse=1 and key_level=1 in the following cycle.
REQ-015 PRESSED: hold_cnt increments each cycle; when key_sync=1 and hold_cnt reaches LONG_CYC-1 -> LONG_HELD, long_flag=1, long_pulse=1 for one cycle.
REQ-016 PRESSED or LONG_HELD: key_sync=0 -> RELEASE_DEB, deb_cnt counts this sample as 1.
REQ-017 RELEASE_DEB: hold_cnt frozen; key_sync=1 -> return to LONG_HELD if long_flag=1, else PRESSED, with no strobe.
REQ-018 RELEASE_DEB: key_sync=0 on DEB_CYC consecutive edges -> IDLE, release_pulse=1, key_level=0, long_flag and hold_cnt cleared.
REQ-019 key_level SHALL be 1 in PRESSED, LONG_HELD and RELEASE_DEB, and 0 in IDLE and PRESS_DEB.
REQ-020 long_pulse SHALL fire at most once per press, including across release bounces.
REQ-021 hold_cnt SHALL saturate, never wrap; deb_cnt SHALL reset on every state change.
REQ-022 press_pulse, release_pulse and long_pulse SHALL be mutually exclusive and never asserted on consecutive cycles for the same event.
REQ-023 en=0 SHALL force IDLE next cycle, clear counters and long_flag, drive key_level=0, and emit no strobes (no release_pulse on forced exit).

Reset
REQ-024 rstn=0 SHALL asynchronously force state IDLE, all counters 0, long_flag 0 and all outputs 0.
REQ-025 After rstn deasserts, the first accepted press SHALL require the full DEB_CYC samples; no strobe SHALL be emitted by the reset itself.
REQ-026 Reset mid-press SHALL discard the press with no release_pulse.

Structure
REQ-027 State enum typedef and default DEB_CYC/LONG_CYC/CNT_W constants SHALL live in shared package key_debounce_pkg.
REQ-028 The block SHALL be a single module with no sub-modules; counters SHALL be inline.

Verification (DEB_CYC=4, LONG_CYC=20, CNT_W=8)
REQ-029 Reset: hold rstn=0 with key_sync=1 -> all outputs 0; after release, press_pulse only after 4 further high samples.
REQ-030 Clean press: key_sync 0->1 held -> press_pulse high exactly one cycle, the cycle after the 4th high sample; key_level rises the same cycle.
REQ-031 Press bounce: pattern 1,1,1,0 repeated 10 times -> press_pulse never asserts, key_level stays 0.
REQ-032 Long press: hold 40 cycles then 0 -> long_pulse 20 cycles after press_pulse, once only; release_pulse after 4 low samples; key_level=0.
REQ-033 Release bounce: while PRESSED, drive 0,0,1 -> no release_pulse, key_level stays 1, long_pulse delayed by exactly 2 cycles.
REQ-034 Abort: en=0 (and separately rstn=0) while LONG_HELD -> IDLE next cycle (immediately for rstn), key_level=0, no release_pulse.
